// File: rtl/conv_window_ctrl_if.sv
// Handshake/status bundle between the pixel source and conv_window_ctrl.
// pix_drop exists only when CONV_WINDOW_CTRL_DROP_DETECT_EN is defined.
interface conv_window_ctrl_if #(
  parameter int CNT_W = 5
);
  logic             start;
  logic             lb_ready;
  logic             pix_valid;
  logic             in_ready;
  logic             pix_accept;
  logic             win_valid;
  logic [CNT_W-1:0] win_row;
  logic [CNT_W-1:0] win_col;
  logic             frame_done;
  logic             busy;
`ifdef CONV_WINDOW_CTRL_DROP_DETECT_EN
  logic             pix_drop;

  modport master (
    output start, lb_ready, pix_valid,
    input  in_ready, pix_accept, win_valid, win_row, win_col, frame_done, busy, pix_drop
  );
  modport slave (
    input  start, lb_ready, pix_valid,
    output in_ready, pix_accept, win_valid, win_row, win_col, frame_done, busy, pix_drop
  );
`else
  modport master (
    output start, lb_ready, pix_valid,
    input  in_ready, pix_accept, win_valid, win_row, win_col, frame_done, busy
  );
  modport slave (
    input  start, lb_ready, pix_valid,
    output in_ready, pix_accept, win_valid, win_row, win_col, frame_done, busy
  );
`endif
endinterface

// File: rtl/conv_window_ctrl.sv
// Raster sequencer for the line-buffer/window datapath: gates pixels, flags strided windows.
// Optional sticky stall-drop flag: define CONV_WINDOW_CTRL_DROP_DETECT_EN.
module conv_window_ctrl #(
  parameter int FIG_WIDTH  = 28,
  parameter int FIG_HEIGHT = 28,
  parameter int KERNEL     = 3,
  parameter int STRIDE     = 1,
  parameter int CNT_W      = 5
) (
  input logic              clk,
  input logic              rst_n,
  conv_window_ctrl_if.slave cw
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(FIG_WIDTH - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(FIG_HEIGHT - 1);
  localparam logic [CNT_W-1:0] K_M1     = CNT_W'(KERNEL - 1);
  localparam logic [CNT_W-1:0] PH_LAST  = CNT_W'(STRIDE - 1);

  state_t           state;
  logic [CNT_W-1:0] row, col, orow, ocol, rphase, cphase;
  logic             row_hit;
  logic             win_valid_q, frame_done_q, busy_q;
  logic [CNT_W-1:0] win_row_q, win_col_q;
  logic             accept, col_wrap, last_pix, hit;

  assign cw.in_ready   = (state == RUN) && cw.lb_ready;
  assign accept        = cw.pix_valid && cw.in_ready;
  assign cw.pix_accept = accept;
  assign cw.win_valid  = win_valid_q;
  assign cw.win_row    = win_row_q;
  assign cw.win_col    = win_col_q;
  assign cw.frame_done = frame_done_q;
  assign cw.busy       = busy_q;

  assign col_wrap = (col == COL_LAST);
  assign last_pix = col_wrap && (row == ROW_LAST);
  assign hit      = (row >= K_M1) && (col >= K_M1) && (rphase == '0) && (cphase == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      row          <= '0;
      col          <= '0;
      orow         <= '0;
      ocol         <= '0;
      rphase       <= '0;
      cphase       <= '0;
      row_hit      <= 1'b0;
      win_valid_q  <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      case (state)
        IDLE: if (cw.start) begin
          state  <= RUN;
          busy_q <= 1'b1;
        end
        RUN: if (accept) begin
          // Window registers see this pixel one cycle later, so coordinates go out registered.
          if (hit) begin
            win_valid_q <= 1'b1;
            win_row_q   <= orow;
            win_col_q   <= ocol;
          end
          if (last_pix) begin
            state        <= DONE;
            frame_done_q <= 1'b1;
            row          <= '0;
            col          <= '0;
            orow         <= '0;
            ocol         <= '0;
            rphase       <= '0;
            cphase       <= '0;
            row_hit      <= 1'b0;
          end else if (col_wrap) begin
            col     <= '0;
            row     <= row + 1'b1;
            cphase  <= '0;
            ocol    <= '0;
            row_hit <= 1'b0;
            if (row >= K_M1) rphase <= (rphase == PH_LAST) ? '0 : rphase + 1'b1;
            if (row_hit || hit) orow <= orow + 1'b1;
          end else begin
            col <= col + 1'b1;
            if (col >= K_M1) cphase <= (cphase == PH_LAST) ? '0 : cphase + 1'b1;
            if (hit) begin
              ocol    <= ocol + 1'b1;
              row_hit <= 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef CONV_WINDOW_CTRL_DROP_DETECT_EN
  logic pix_drop_q;
  assign cw.pix_drop = pix_drop_q;

  // Sticky: upstream offered a pixel while the line buffers were not ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           pix_drop_q <= 1'b0;
    else if (state == IDLE && cw.start)                   pix_drop_q <= 1'b0;
    else if (state == RUN && cw.pix_valid && !cw.in_ready) pix_drop_q <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_conv_window_ctrl.sv
// Scoreboard bench: three configurations (5x5 S1, 5x5 S2, 8x8 S1) driven one at a time.
module tb_conv_window_ctrl;
  localparam int CW = 5;
  localparam int K  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0, lb_ready = 1'b1, pix_valid = 1'b0;
  int   sel = 0;

  conv_window_ctrl_if #(.CNT_W(CW)) if_a ();
  conv_window_ctrl_if #(.CNT_W(CW)) if_b ();
  conv_window_ctrl_if #(.CNT_W(CW)) if_c ();

  assign if_a.start = start && (sel == 0);
  assign if_b.start = start && (sel == 1);
  assign if_c.start = start && (sel == 2);
  assign if_a.pix_valid = pix_valid && (sel == 0);
  assign if_b.pix_valid = pix_valid && (sel == 1);
  assign if_c.pix_valid = pix_valid && (sel == 2);
  assign if_a.lb_ready = lb_ready;
  assign if_b.lb_ready = lb_ready;
  assign if_c.lb_ready = lb_ready;

  conv_window_ctrl #(.FIG_WIDTH(5), .FIG_HEIGHT(5), .KERNEL(K), .STRIDE(1), .CNT_W(CW))
    dut_a (.clk(clk), .rst_n(rst_n), .cw(if_a.slave));
  conv_window_ctrl #(.FIG_WIDTH(5), .FIG_HEIGHT(5), .KERNEL(K), .STRIDE(2), .CNT_W(CW))
    dut_b (.clk(clk), .rst_n(rst_n), .cw(if_b.slave));
  conv_window_ctrl #(.FIG_WIDTH(8), .FIG_HEIGHT(8), .KERNEL(K), .STRIDE(1), .CNT_W(CW))
    dut_c (.clk(clk), .rst_n(rst_n), .cw(if_c.slave));

  logic          m_rdy, m_acc, m_wv, m_fd, m_busy, m_drop;
  logic [CW-1:0] m_row, m_col;

  always_comb begin
    m_rdy = if_a.in_ready; m_acc = if_a.pix_accept; m_wv = if_a.win_valid;
    m_fd = if_a.frame_done; m_busy = if_a.busy; m_row = if_a.win_row; m_col = if_a.win_col;
    m_drop = 1'b0;
`ifdef CONV_WINDOW_CTRL_DROP_DETECT_EN
    m_drop = if_a.pix_drop;
`endif
    if (sel == 1) begin
      m_rdy = if_b.in_ready; m_acc = if_b.pix_accept; m_wv = if_b.win_valid;
      m_fd = if_b.frame_done; m_busy = if_b.busy; m_row = if_b.win_row; m_col = if_b.win_col;
`ifdef CONV_WINDOW_CTRL_DROP_DETECT_EN
      m_drop = if_b.pix_drop;
`endif
    end else if (sel == 2) begin
      m_rdy = if_c.in_ready; m_acc = if_c.pix_accept; m_wv = if_c.win_valid;
      m_fd = if_c.frame_done; m_busy = if_c.busy; m_row = if_c.win_row; m_col = if_c.win_col;
`ifdef CONV_WINDOW_CTRL_DROP_DETECT_EN
      m_drop = if_c.pix_drop;
`endif
    end
  end

  int n_chk = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: frame geometry, pixel index, and spec-level run/done flags.
  int mw = 5, mh = 5, ms = 1, n = 0, win_seen = 0;
  bit running = 0, done_ph = 0, drop_m = 0;

  typedef struct { int cyc; int r; int c; } win_t;
  win_t wq[$];
  int   fq[$];
  win_t mon_e;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a window or frame_done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_wv) begin
        win_seen++;
        chk("win_expected", int'(wq.size() > 0), 1);
        if (wq.size() > 0) begin
          mon_e = wq.pop_front();
          chk("win_row", int'(m_row), mon_e.r);
          chk("win_col", int'(m_col), mon_e.c);
          chk("win_latency", cyc, mon_e.cyc);
        end
      end
      if (m_fd) begin
        chk("fd_expected", int'(fq.size() > 0), 1);
        if (fq.size() > 0) chk("frame_done_latency", cyc, fq.pop_front());
      end
    end
  end

  // One clock of stimulus: inputs set 1 after the edge, model advanced after the next edge.
  task automatic step(input bit pv, input bit lr, input bit st);
    bit   acc, was_run, was_done;
    int   r, c;
    win_t e;
    was_run = running; was_done = done_ph;
    pix_valid = pv; lb_ready = lr; start = st;
    #1;
    chk("in_ready", int'(m_rdy), int'(was_run && lr));
    acc = pv && lr && was_run;
    chk("pix_accept", int'(m_acc), int'(acc));
    @(posedge clk); #1;
    if (was_run && pv && !lr) drop_m = 1;
    if (was_done) done_ph = 0;
    else if (st && !was_run) begin running = 1; drop_m = 0; end
    if (acc) begin
      r = n / mw; c = n % mw;
      if (r >= K-1 && c >= K-1 && (r-K+1) % ms == 0 && (c-K+1) % ms == 0) begin
        e.cyc = cyc; e.r = (r-K+1) / ms; e.c = (c-K+1) / ms;
        wq.push_back(e);
      end
      n++;
      if (n == mw*mh) begin fq.push_back(cyc); running = 0; done_ph = 1; n = 0; end
    end
    chk("busy", int'(m_busy), int'(running || done_ph));
`ifdef CONV_WINDOW_CTRL_DROP_DETECT_EN
    chk("pix_drop", int'(m_drop), int'(drop_m));
`endif
    pix_valid = 0; start = 0;
  endtask

  task automatic do_abort();
    rst_n = 0;
    #1;
    chk("abort_win_valid", int'(m_wv), 0);
    chk("abort_win_row", int'(m_row), 0);
    chk("abort_win_col", int'(m_col), 0);
    chk("abort_frame_done", int'(m_fd), 0);
    chk("abort_busy", int'(m_busy), 0);
    chk("abort_in_ready", int'(m_rdy), 0);
`ifdef CONV_WINDOW_CTRL_DROP_DETECT_EN
    chk("abort_pix_drop", int'(m_drop), 0);
`endif
    wq.delete(); fq.delete();
    running = 0; done_ph = 0; drop_m = 0; n = 0; win_seen = 0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic run_frame(input int pv_pct, input int stall_at, input int stall_len,
                           input int start_at, input int abort_at);
    int guard = 0, stalled = 0;
    bit st_done = 0, pv, lr, st;
    win_seen = 0;
    step(0, 1, 1);
    while (running && guard < 3000) begin
      guard++;
      if (abort_at >= 0 && n == abort_at) begin
        do_abort();
        return;
      end
      pv = ($urandom_range(99) < pv_pct);
      lr = 1;
      if (n == stall_at && stalled < stall_len) begin lr = 0; pv = 1; stalled++; end
      st = 0;
      if (n == start_at && !st_done) begin st = 1; st_done = 1; end
      step(pv, lr, st);
    end
    chk("frame_timeout", int'(running), 0);
    step(0, 1, 0);
    chk("win_count", win_seen, ((mh-K)/ms + 1) * ((mw-K)/ms + 1));
    chk("win_queue_drained", wq.size(), 0);
    chk("fd_queue_drained", fq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_win_valid", int'(m_wv), 0);
    chk("rst_win_row", int'(m_row), 0);
    chk("rst_win_col", int'(m_col), 0);
    chk("rst_frame_done", int'(m_fd), 0);
    chk("rst_busy", int'(m_busy), 0);
    chk("rst_in_ready", int'(m_rdy), 0);
    #10 rst_n = 1;
    @(posedge clk); #1;

    // 5x5 S1: full-rate frame, stalled frame, ignored start/pix_valid, abort + restart
    sel = 0; mw = 5; mh = 5; ms = 1;
    run_frame(100, -1, 0, -1, -1);
    run_frame(100, 14, 4, -1, -1);
`ifdef CONV_WINDOW_CTRL_DROP_DETECT_EN
    chk("drop_after_stall", int'(m_drop), 1);
`endif
    step(1, 1, 0);
    step(1, 1, 0);
    run_frame(100, -1, 0, 7, -1);
    run_frame(100, -1, 0, -1, 17);
    run_frame(100, -1, 0, -1, -1);

    // 5x5 S2
    sel = 1; mw = 5; mh = 5; ms = 2;
    step(0, 1, 0);
    run_frame(100, -1, 0, -1, -1);
    run_frame(70, 9, 3, -1, -1);

    // 8x8 S1, random pix_valid
    sel = 2; mw = 8; mh = 8; ms = 1;
    step(0, 1, 0);
    run_frame(50, -1, 0, -1, -1);
    run_frame(50, 30, 2, 12, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
